// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// Shift-add multiply and restoring divide on operand magnitudes, one bit per cycle, sign fixed up at the end.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             abort,
    input  logic             whi,
    input  logic             wlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // acc holds the running product upper half / partial remainder; shr holds the multiplier / dividend-then-quotient.
    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & srca[WIDTH-1];
        b_neg     = is_signed & srcb[WIDTH-1];
        a_mag     = a_neg ? -srca : srca;
        b_mag     = b_neg ? -srcb : srcb;
        mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_q, shr_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, m_q};
        prod      = {acc_q, shr_q};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = (m_q == '0) ? '1 : (neg_q ? -shr_q : shr_q);
        rem_fix   = neg_rem_q ? -acc_q : acc_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        shr_d     = shr_q;
        m_d       = m_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = op[1];
                    acc_d     = '0;
                    shr_d     = op[1] ? a_mag : b_mag;
                    m_d       = op[1] ? b_mag : a_mag;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                end else begin
                    if (whi) hi_d = wdata;
                    if (wlo) lo_d = wdata;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        shr_d = {shr_q[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            shr_q     <= '0;
            m_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            shr_q     <= shr_d;
            m_q       <= m_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: a 32-bit instance for the main directed vectors and an 8-bit instance for the narrow build.
module tb_mips_muldiv_unit;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        abort;
    logic        whi;
    logic        wlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  srca8;
    logic [7:0]  srcb8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    exp_t q32[$];
    exp_t q8[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;

    always #5 clk = ~clk;

    mips_muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .abort (abort),
        .whi   (whi),
        .wlo   (wlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .op    (op8),
        .srca  (srca8),
        .srcb  (srcb8),
        .abort (1'b0),
        .whi   (1'b0),
        .wlo   (1'b0),
        .wdata (8'h00),
        .busy  (busy8),
        .done  (done8),
        .hi    (hi8),
        .lo    (lo8)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives one start cycle on the 32-bit unit, optionally with abort/mthi/mtlo in the same cycle.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic ab, input logic wh, input logic wl, input logic [31:0] wd,
                                 input logic push, input string name, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; srca = a; srcb = b; abort = ab; whi = wh; wlo = wl; wdata = wd; start = 1'b1;
        if (push) begin
            e.name = name; e.hi = eh; e.lo = el;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0; whi = 1'b0; wlo = 1'b0;
    endtask

    task automatic applyStimulus8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input string name, input logic [7:0] eh, input logic [7:0] el);
        exp_t e;
        @(posedge clk);
        #1;
        op8 = o; srca8 = a; srcb8 = b; start8 = 1'b1;
        e.name = name; e.hi = {24'h0, eh}; e.lo = {24'h0, el};
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic writeHiLo(input logic wh, input logic wl, input logic [31:0] wd);
        @(posedge clk);
        #1;
        whi = wh; wlo = wl; wdata = wd;
        @(posedge clk);
        #1;
        whi = 1'b0; wlo = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) checkOutput({name, "_timeout"}, busy, 1'b0);
    endtask

    // Scoreboard for the 32-bit unit: every done pulse pops one expectation.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_count++;
            checkOutput("done_with_busy", busy, 1'b0);
            checkOutput("sb32_has_entry", q32.size() > 0, 1'b1);
            if (q32.size() > 0) begin
                e = q32.pop_front();
                checkOutput({e.name, "_hi"}, hi, e.hi);
                checkOutput({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    // Scoreboard for the 8-bit unit.
    always @(negedge clk) begin
        if (done8) begin
            exp_t e;
            checkOutput("sb8_has_entry", q8.size() > 0, 1'b1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                checkOutput({e.name, "_hi"}, {24'h0, hi8}, e.hi);
                checkOutput({e.name, "_lo"}, {24'h0, lo8}, e.lo);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int dc;
        reset = 1'b1; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        abort = 1'b0; whi = 1'b0; wlo = 1'b0; wdata = '0;
        start8 = 1'b0; op8 = 2'b00; srca8 = '0; srcb8 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);

        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("multu_busy_cycles", n, 33);
        checkOutput("multu_done_pulse", done, 1'b1);
        @(negedge clk);
        checkOutput("multu_done_low", done, 1'b0);

        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        waitIdle("mult_neg3x5");
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        waitIdle("div_neg7by2");
        applyStimulus(2'b11, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "divu_7by2", 32'd1, 32'd3);
        waitIdle("divu_7by2");
        applyStimulus(2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "divu_by0", 32'h1234_5678, 32'hFFFF_FFFF);
        waitIdle("divu_by0");
        applyStimulus(2'b10, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "div_neg_by0", 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        waitIdle("div_neg_by0");
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "div_min_by_m1", 32'h0, 32'h8000_0000);
        waitIdle("div_min_by_m1");

        applyStimulus(2'b00, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, "mult_vs_mthi", 32'h0, 32'd6);
        @(negedge clk);
        checkOutput("start_beats_mthi", hi, 32'h0);
        waitIdle("mult_vs_mthi");

        applyStimulus(2'b01, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, "", 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("start_abort_idle_busy", busy, 1'b0);
        checkOutput("start_abort_idle_lo", lo, 32'd6);

        writeHiLo(1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        checkOutput("mthi_mtlo_both_hi", hi, 32'h1234_5678);
        checkOutput("mthi_mtlo_both_lo", lo, 32'h1234_5678);

        writeHiLo(1'b1, 1'b0, 32'hAAAA_0000);
        writeHiLo(1'b0, 1'b1, 32'h0000_BBBB);
        @(negedge clk);
        checkOutput("preload_hi", hi, 32'hAAAA_0000);
        checkOutput("preload_lo", lo, 32'h0000_BBBB);

        dc = done_count;
        applyStimulus(2'b00, 32'd4, 32'd4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "", 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; srca = 32'd50; srcb = 32'd5; whi = 1'b1; wdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        start = 1'b0; whi = 1'b0;
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_hi", hi, 32'hAAAA_0000);
        checkOutput("abort_lo", lo, 32'h0000_BBBB);
        repeat (40) @(negedge clk);
        checkOutput("abort_no_done", done_count, dc);
        checkOutput("abort_still_idle", busy, 1'b0);
        checkOutput("abort_hi_later", hi, 32'hAAAA_0000);

        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, "", 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_done", done, 1'b0);
        checkOutput("midreset_hi", hi, 32'h0);
        checkOutput("midreset_lo", lo, 32'h0);
        applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, "divu_after_reset", 32'd2, 32'd14);
        waitIdle("divu_after_reset");

        applyStimulus8(2'b01, 8'hFF, 8'hFF, "w8_multu", 8'hFE, 8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 50);
        checkOutput("w8_latency", n, 10);
        applyStimulus8(2'b10, 8'h80, 8'hFF, "w8_div_min", 8'h00, 8'h80);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 50);
        checkOutput("w8_div_latency", n, 10);

        repeat (5) @(negedge clk);
        checkOutput("sb32_drained", q32.size(), 0);
        checkOutput("sb8_drained", q8.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit (MDU) for the pipelined MIPS core, fed from the Execute stage.
- Implements mult, multu, div and divu into HI/LO registers; mthi/mtlo write them, mfhi/mflo read them.
- Datapath width is parametrised.
- Stalls the pipeline through `busy` while an operation runs; `abort` cancels an in-flight operation when the issuing instruction is flushed.

Parameters:
- WIDTH, 32, operand and HI/LO width. Must be even and >= 4.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on the clock edge.
- op  input  2  operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- srca  input  WIDTH  multiplicand / dividend (rs).
- srcb  input  WIDTH  multiplier / divisor (rt).
- abort  input  1  cancel the in-flight operation (driven by flushE).
- whi  input  1  mthi write enable.
- wlo  input  1  mtlo write enable.
- wdata  input  WIDTH  mthi/mtlo data.
- busy  output  1  operation in progress; the hazard unit stalls F/D/E on busy or start.
- done  output  1  one-cycle pulse: HI/LO were just updated by an operation.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
  - Reset takes priority over all inputs, including mid-operation; any partial result is discarded.
- States:
  - IDLE: accepts start and mthi/mtlo.
  - RUN: exactly WIDTH cycles, one bit per cycle. Multiply is shift-add on magnitudes; divide is restoring division on magnitudes.
  - FIX: one cycle. Applies sign correction and writes HI/LO.
- Transitions:
  - IDLE -> RUN on start & !abort. Operands and op are captured at this edge.
  - RUN -> FIX when the counter reaches WIDTH-1.
  - FIX -> IDLE always.
  - RUN/FIX -> IDLE on abort. HI/LO are unchanged and done is not pulsed.
- busy:
  - busy=1 in RUN and FIX, otherwise 0.
  - It is registered: high starting the cycle after start is accepted.
- Latency: start sampled at edge N. HI/LO hold new values, done=1 and busy=0 in the cycle after edge N+WIDTH+1. done lasts exactly one cycle.
- start while busy is ignored; the current operation continues undisturbed.
- start & abort in the same IDLE cycle: abort wins, no operation starts.
- mthi/mtlo:
  - whi/wlo update hi/lo at the edge, in IDLE only.
  - Ignored while busy.
  - If asserted in the same cycle as an accepted start, the start wins and the write is dropped.
  - whi and wlo may be asserted together; both registers take wdata.
- Signed operations:
  - Operand magnitudes are taken at capture; the result sign is applied in FIX.
  - mult: {hi,lo} = exact 2*WIDTH-bit two's-complement product.
  - div: quotient truncates toward zero; remainder takes the sign of the dividend; |remainder| < |divisor|.
  - div of MIN_INT by -1: lo=MIN_INT, hi=0 (no trap).
- Divide by zero (div or divu): lo = all ones, hi = dividend unchanged. Timing is the normal latency; no exception is raised.
- Unsigned operations: operands are treated as WIDTH-bit unsigned. multu gives an exact 2*WIDTH-bit product.
- hi/lo change only at FIX completion, on an mthi/mtlo write, or on reset. The values of an aborted operation never become visible.
- done is never asserted in the same cycle as busy.

Test Plan:
- WIDTH=32 multu, srca=srcb=0xFFFFFFFF:
  - busy from the next cycle for 33 cycles;
  - then done=1 with hi=0xFFFFFFFE, lo=0x00000001;
  - done low the following cycle.
- mult -3 x 5 (srca=0xFFFFFFFD, srcb=5) -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Then div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then divu 7/2 -> lo=3, hi=1.
- divu 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - Then div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload via mthi=0xAAAA0000 and mtlo=0x0000BBBB:
  - start mult 4x4, assert abort at RUN cycle 10 -> busy=0 next cycle, done never asserted, hi/lo still 0xAAAA0000/0x0000BBBB;
  - a second start while busy is ignored;
  - an mthi while busy is ignored.
- Assert reset at RUN cycle 5 of divu -> next cycle busy=0, done=0, hi=lo=0.
  - A start on the following cycle runs normally to the correct result.
- WIDTH=8 build:
  - multu 0xFF x 0xFF -> hi=0xFE, lo=0x01, done 10 cycles after the start edge;
  - div 0x80 / 0xFF -> lo=0x80, hi=0x00.
